spart_reader: RTL and testbench

- Serial UART receiver: the receive-side counterpart of the SPART transmit path.
- Samples an asynchronous 8N1 `rxd` line with 16x oversampling and assembles bytes LSB-first.
- Presents each byte in a single holding register with a data-available flag, plus framing and overrun status.
- Sits beside the transmit writer in the SPART/PS2 subsystem so the host side can send commands into the design.

---
 rtl/spart_reader.sv | 175 +++++++++++++++++
 tb/tb_spart_reader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spart_reader.sv
// SPART serial receiver: 8N1 with 16x oversampling, one holding register plus rda/framing/overrun status.
// Defining SPART_READER_PARITY_EN adds an even-parity bit after the data bits and a parity_err output.
module spart_reader #(
  parameter int DIVISOR = 651
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       read,
  output logic [7:0] data_out,
  output logic       rda,
  output logic       framing_err,
  output logic       overrun
`ifdef SPART_READER_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [15:0] DIV_MAX = 16'(DIVISOR - 1);

`ifdef SPART_READER_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t      state_q, state_d;
  logic        rxd_m_q, rxd_s_q;
  logic [15:0] div_q, div_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        rda_q, rda_d, fe_q, fe_d, ov_q, ov_d;
  logic        tick, mid, commit;
`ifdef SPART_READER_PARITY_EN
  logic        par_q, par_d, pe_q, pe_d;
`endif

  assign tick = (div_q == DIV_MAX);
  assign mid  = tick && (scnt_q == 4'd15);

  always_comb begin
    state_d = state_q;
    // Divider only runs inside a frame so ticks are phase-locked to the start edge.
    div_d   = (state_q == S_IDLE || state_q == S_BREAK) ? 16'd0 :
              (tick ? 16'd0 : div_q + 16'd1);
    scnt_d  = tick ? scnt_q + 4'd1 : scnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    commit  = 1'b0;
`ifdef SPART_READER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        scnt_d = 4'd0;
        bidx_d = 3'd0;
        if (!rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (tick && scnt_q == 4'd7) begin
          scnt_d = 4'd0;
          bidx_d = 3'd0;
          state_d = rxd_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_d = {rxd_s_q, shift_q[7:1]};
          bidx_d  = bidx_q + 3'd1;
`ifdef SPART_READER_PARITY_EN
          if (bidx_q == 3'd7) state_d = S_PARITY;
`else
          if (bidx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef SPART_READER_PARITY_EN
      S_PARITY: begin
        if (mid) begin
          par_d   = rxd_s_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (mid) begin
          commit  = 1'b1;
          state_d = rxd_s_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: a commit always wins; a read alone clears the status flags.
  always_comb begin
    data_d = data_q;
    rda_d  = rda_q;
    fe_d   = fe_q;
    ov_d   = ov_q;
`ifdef SPART_READER_PARITY_EN
    pe_d   = pe_q;
`endif
    if (commit) begin
      data_d = shift_q;
      rda_d  = 1'b1;
      fe_d   = ~rxd_s_q;
      ov_d   = rda_q & ~read;
`ifdef SPART_READER_PARITY_EN
      pe_d   = ^{shift_q, par_q};
`endif
    end else if (read && rda_q) begin
      rda_d = 1'b0;
      fe_d  = 1'b0;
      ov_d  = 1'b0;
`ifdef SPART_READER_PARITY_EN
      pe_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rxd_m_q <= 1'b1;
      rxd_s_q <= 1'b1;
      div_q   <= 16'd0;
      scnt_q  <= 4'd0;
      bidx_q  <= 3'd0;
      data_q  <= 8'h00;
      rda_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef SPART_READER_PARITY_EN
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rxd_m_q <= rxd;
      rxd_s_q <= rxd_m_q;
      div_q   <= div_d;
      scnt_q  <= scnt_d;
      bidx_q  <= bidx_d;
      data_q  <= data_d;
      rda_q   <= rda_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef SPART_READER_PARITY_EN
      pe_q    <= pe_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef SPART_READER_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign data_out    = data_q;
  assign rda         = rda_q;
  assign framing_err = fe_q;
  assign overrun     = ov_q;
`ifdef SPART_READER_PARITY_EN
  assign parity_err  = pe_q;
`endif

endmodule

// File: tb/tb_spart_reader.sv
// Directed bench for spart_reader at DIVISOR=4 (64 clk per bit); inputs driven and outputs sampled on negedge.
module tb_spart_reader;

  localparam int BIT = 64;
`ifdef SPART_READER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Negedges from the start-bit edge to the one just before the commit posedge.
  localparam int COMMIT_NEG = 610 + BIT * PAR;

  logic       clk = 1'b0;
  logic       rst, rxd, read;
  logic [7:0] data_out;
  logic       rda, framing_err, overrun;
`ifdef SPART_READER_PARITY_EN
  logic       parity_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spart_reader #(.DIVISOR(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .read(read),
    .data_out(data_out), .rda(rda), .framing_err(framing_err), .overrun(overrun)
`ifdef SPART_READER_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves rxd at the stop-bit level when done.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    rxd = 1'b0;
    wait_neg(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_neg(BIT);
    end
`ifdef SPART_READER_PARITY_EN
    rxd = par;
    wait_neg(BIT);
`else
    if (par) rxd = 1'b1;
`endif
    rxd = stop;
    wait_neg(BIT);
  endtask

  task automatic pulse_read();
    read = 1'b1;
    wait_neg(1);
    read = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; read = 1'b0;
    wait_neg(3);
    chk("rst_data", data_out, 8'h00);
    chk("rst_rda", {7'd0, rda}, 8'd0);
    chk("rst_fe", {7'd0, framing_err}, 8'd0);
    chk("rst_ov", {7'd0, overrun}, 8'd0);
    rst = 1'b0;
    wait_neg(10);

    send_frame(8'hA5, 1'b1, ^8'hA5);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_rda", {7'd0, rda}, 8'd1);
    chk("a5_fe", {7'd0, framing_err}, 8'd0);
    chk("a5_ov", {7'd0, overrun}, 8'd0);
    pulse_read();
    chk("a5_rd_rda", {7'd0, rda}, 8'd0);
    chk("a5_rd_data", data_out, 8'hA5);
    wait_neg(20);

    rxd = 1'b0;
    wait_neg(20);
    rxd = 1'b1;
    wait_neg(150);
    chk("glitch_rda", {7'd0, rda}, 8'd0);
    chk("glitch_fe", {7'd0, framing_err}, 8'd0);
    chk("glitch_ov", {7'd0, overrun}, 8'd0);

    send_frame(8'h3C, 1'b1, ^8'h3C);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    chk("ovr_data", data_out, 8'hC3);
    chk("ovr_rda", {7'd0, rda}, 8'd1);
    chk("ovr_ov", {7'd0, overrun}, 8'd1);
    pulse_read();
    chk("ovr_rd_rda", {7'd0, rda}, 8'd0);
    chk("ovr_rd_ov", {7'd0, overrun}, 8'd0);
    wait_neg(20);

    send_frame(8'h55, 1'b0, ^8'h55);
    chk("brk_data", data_out, 8'h55);
    chk("brk_fe", {7'd0, framing_err}, 8'd1);
    chk("brk_rda", {7'd0, rda}, 8'd1);
    chk("brk_ov", {7'd0, overrun}, 8'd0);
    pulse_read();
    chk("brk_rd_rda", {7'd0, rda}, 8'd0);
    wait_neg(500 - BIT);
    chk("brk_low_rda", {7'd0, rda}, 8'd0);
    rxd = 1'b1;
    wait_neg(100);
    chk("brk_high_rda", {7'd0, rda}, 8'd0);

    send_frame(8'hF0, 1'b1, ^8'hF0);
    chk("f0_data", data_out, 8'hF0);
    chk("f0_rda", {7'd0, rda}, 8'd1);
    fork
      send_frame(8'h0F, 1'b1, ^8'h0F);
      begin
        wait_neg(COMMIT_NEG);
        read = 1'b1;
        wait_neg(1);
        read = 1'b0;
        chk("coin_data", data_out, 8'h0F);
        chk("coin_rda", {7'd0, rda}, 8'd1);
        chk("coin_ov", {7'd0, overrun}, 8'd0);
        chk("coin_fe", {7'd0, framing_err}, 8'd0);
      end
    join
    wait_neg(20);

    // Reset lands in data bit 4; bits 4..7 (and parity) of 8'hF4 are high, so no false start follows.
    fork
      send_frame(8'hF4, 1'b1, ^8'hF4);
      begin
        wait_neg(350);
        rst = 1'b1;
        #1;
        chk("mrst_data", data_out, 8'h00);
        chk("mrst_rda", {7'd0, rda}, 8'd0);
        chk("mrst_fe", {7'd0, framing_err}, 8'd0);
        chk("mrst_ov", {7'd0, overrun}, 8'd0);
        wait_neg(1);
        rst = 1'b0;
      end
    join
    wait_neg(100);
    chk("mrst_nocommit", {7'd0, rda}, 8'd0);
    send_frame(8'h81, 1'b1, ^8'h81);
    chk("x81_data", data_out, 8'h81);
    chk("x81_rda", {7'd0, rda}, 8'd1);
    chk("x81_fe", {7'd0, framing_err}, 8'd0);
    chk("x81_ov", {7'd0, overrun}, 8'd0);

`ifdef SPART_READER_PARITY_EN
    pulse_read();
    wait_neg(20);
    send_frame(8'h07, 1'b1, 1'b0);
    chk("par0_data", data_out, 8'h07);
    chk("par0_pe", {7'd0, parity_err}, 8'd1);
    pulse_read();
    chk("par0_rd_pe", {7'd0, parity_err}, 8'd0);
    wait_neg(20);
    send_frame(8'h07, 1'b1, 1'b1);
    chk("par1_pe", {7'd0, parity_err}, 8'd0);
    chk("par1_rda", {7'd0, rda}, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
